// File: rtl/alsu_pkg.sv
// rtl/alsu_pkg.sv - shared ALSU command layout, opcode and driver FSM types
package alsu_pkg;

  localparam int LATENCY_DEF = 2;
  localparam int TAG_W_DEF   = 4;
  localparam int ERR_W_DEF   = 8;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  // Field order matches the cmd_data bit layout, MSB first
  typedef struct packed {
    opcode_e    opcode;     // [15:13]
    logic [2:0] a;          // [12:10]
    logic [2:0] b;          // [9:7]
    logic       cin;        // [6]
    logic       serial_in;  // [5]
    logic       direction;  // [4]
    logic       red_op_a;   // [3]
    logic       red_op_b;   // [2]
    logic       bypass_a;   // [1]
    logic       bypass_b;   // [0]
  } alsu_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Builds a packed command word from individual fields
  function automatic logic [15:0] make_cmd(
    opcode_e    op,
    logic [2:0] a,
    logic [2:0] b,
    logic       cin,
    logic       serial_in,
    logic       direction,
    logic       red_op_a,
    logic       red_op_b,
    logic       bypass_a,
    logic       bypass_b
  );
    alsu_cmd_t c;
    c.opcode    = op;
    c.a         = a;
    c.b         = b;
    c.cin       = cin;
    c.serial_in = serial_in;
    c.direction = direction;
    c.red_op_a  = red_op_a;
    c.red_op_b  = red_op_b;
    c.bypass_a  = bypass_a;
    c.bypass_b  = bypass_b;
    return c;
  endfunction

endpackage

// File: rtl/alsu_cmd_driver_if.sv
// rtl/alsu_cmd_driver_if.sv - command and response stream bundle for the ALSU driver
interface alsu_cmd_driver_if #(
  parameter int TAG_W = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_out;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  // Command source / response sink side
  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_err, rsp_tag
  );

  // Driver side
  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_err, rsp_tag
  );

endinterface

// File: rtl/alsu_cmd_driver.sv
// rtl/alsu_cmd_driver.sv - drives one command into the ALSU, waits its latency, returns tagged result
module alsu_cmd_driver
  import alsu_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int ERR_W   = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  alsu_cmd_driver_if.slave bus,
  output logic [ERR_W-1:0] err_count_o,
  output logic [2:0]       alsu_a_o,
  output logic [2:0]       alsu_b_o,
  output logic [2:0]       alsu_opcode_o,
  output logic             alsu_cin_o,
  output logic             alsu_serial_in_o,
  output logic             alsu_direction_o,
  output logic             alsu_red_op_a_o,
  output logic             alsu_red_op_b_o,
  output logic             alsu_bypass_a_o,
  output logic             alsu_bypass_b_o,
  input  logic [5:0]       alsu_out_i,
  input  logic [15:0]      alsu_leds_i
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LATENCY - 1);

  state_e           state_q;
  alsu_cmd_t        drv_q;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [5:0]       rsp_out_q;
  logic             rsp_err_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [TAG_W-1:0] tag_cnt_q;
  logic [TAG_W-1:0] tag_cnt_d;
  logic [ERR_W-1:0] err_cnt_q;
  logic [ERR_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             leds_any;

  assign tag_cnt_d = tag_cnt_q + TAG_W'(1);
  assign err_cnt_d = err_cnt_q + ERR_W'(1);
  assign leds_any  = |alsu_leds_i;

  // Handshake FSM; the ALSU drives are registered and only non-zero during LAUNCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drv_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      tag_cnt_q   <= '0;
      err_cnt_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            drv_q       <= alsu_cmd_t'(bus.cmd_data);
            rsp_tag_q   <= tag_cnt_q;
            tag_cnt_q   <= tag_cnt_d;
            cmd_ready_q <= 1'b0;
            state_q     <= LAUNCH;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        LAUNCH: begin
          drv_q      <= '0;
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt_q == LAST_WAIT) begin
            rsp_out_q   <= alsu_out_i;
            rsp_err_q   <= leds_any;
            if (leds_any && (err_cnt_q != '1)) begin
              err_cnt_q <= err_cnt_d;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign err_count_o   = err_cnt_q;

  assign alsu_opcode_o    = drv_q.opcode;
  assign alsu_a_o         = drv_q.a;
  assign alsu_b_o         = drv_q.b;
  assign alsu_cin_o       = drv_q.cin;
  assign alsu_serial_in_o = drv_q.serial_in;
  assign alsu_direction_o = drv_q.direction;
  assign alsu_red_op_a_o  = drv_q.red_op_a;
  assign alsu_red_op_b_o  = drv_q.red_op_b;
  assign alsu_bypass_a_o  = drv_q.bypass_a;
  assign alsu_bypass_b_o  = drv_q.bypass_b;

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// tb/tb_alsu_cmd_driver.sv - directed bench for alsu_cmd_driver with a two-stage ALSU model
module tb_alsu_cmd_driver;
  import alsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  alsu_cmd_driver_if #(.TAG_W(4)) bus ();

  logic [7:0]  err_count;
  logic [2:0]  alsu_a, alsu_b, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_direction;
  logic        alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic [15:0] drv_all;

  assign drv_all = {alsu_opcode, alsu_a, alsu_b, alsu_cin, alsu_serial_in, alsu_direction,
                    alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b};

  alsu_cmd_driver #(.LATENCY(2), .TAG_W(4), .ERR_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .err_count_o      (err_count),
    .alsu_a_o         (alsu_a),
    .alsu_b_o         (alsu_b),
    .alsu_opcode_o    (alsu_opcode),
    .alsu_cin_o       (alsu_cin),
    .alsu_serial_in_o (alsu_serial_in),
    .alsu_direction_o (alsu_direction),
    .alsu_red_op_a_o  (alsu_red_op_a),
    .alsu_red_op_b_o  (alsu_red_op_b),
    .alsu_bypass_a_o  (alsu_bypass_a),
    .alsu_bypass_b_o  (alsu_bypass_b),
    .alsu_out_i       (alsu_out),
    .alsu_leds_i      (alsu_leds)
  );

  // ALSU model: input register stage, then output register stage
  logic [2:0] m_a, m_b, m_op;
  logic       m_cin, m_si, m_dir, m_ra, m_rb, m_ba, m_bb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_a, m_b, m_op, m_cin, m_si, m_dir, m_ra, m_rb, m_ba, m_bb} <= '0;
      alsu_out  <= '0;
      alsu_leds <= '0;
    end else begin
      m_a <= alsu_a; m_b <= alsu_b; m_op <= alsu_opcode; m_cin <= alsu_cin;
      m_si <= alsu_serial_in; m_dir <= alsu_direction; m_ra <= alsu_red_op_a;
      m_rb <= alsu_red_op_b; m_ba <= alsu_bypass_a; m_bb <= alsu_bypass_b;
      if (m_op > 3'd5 || ((m_ra || m_rb) && m_op > 3'd1)) begin
        alsu_out  <= '0;
        alsu_leds <= 16'hFFFF;
      end else begin
        alsu_leds <= '0;
        if (m_ba) alsu_out <= {3'b0, m_a};
        else if (m_bb) alsu_out <= {3'b0, m_b};
        else begin
          case (m_op)
            3'd0: alsu_out <= m_ra ? {5'b0, |m_a} : m_rb ? {5'b0, |m_b} : {3'b0, m_a | m_b};
            3'd1: alsu_out <= m_ra ? {5'b0, ^m_a} : m_rb ? {5'b0, ^m_b} : {3'b0, m_a ^ m_b};
            3'd2: alsu_out <= {3'b0, m_a} + {3'b0, m_b} + {5'b0, m_cin};
            3'd3: alsu_out <= {3'b0, m_a} * {3'b0, m_b};
            3'd4: alsu_out <= m_dir ? {alsu_out[4:0], m_si} : {m_si, alsu_out[5:1]};
            3'd5: alsu_out <= m_dir ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
            default: alsu_out <= '0;
          endcase
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offers a command at a negedge; returns the cycle it was accepted in
  task automatic send_cmd(input logic [15:0] d, output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = -1;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cmd_ready) begin
        acc_cyc = cyc;
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus.rsp_valid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [15:0] d, output logic [5:0] out, output logic err,
                         output logic [3:0] tag, output bit ok);
    int  acc;
    bit  ok1, ok2;
    send_cmd(d, acc, ok1);
    ok2 = 1'b0;
    if (ok1) wait_rsp(ok2);
    ok  = ok1 && ok2;
    out = bus.rsp_out;
    err = bus.rsp_err;
    tag = bus.rsp_tag;
    if (ok) handshake();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count, drv_all} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b vld=%0b out=%0d err=%0b tag=%0d cnt=%0d drv=%h want all 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count, drv_all);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready got %0b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_mult();
    logic [15:0] d;
    int acc;
    bit ok;
    d = make_cmd(MULT, 3'd7, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_cmd(d, acc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mult_accept got timeout want accept"); end
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, drv_all} !== {2'b00, d}) begin
      errors++;
      $display("FAIL mult_launch got rdy=%0b vld=%0b drv=%h want rdy=0 vld=0 drv=%h",
               bus.cmd_ready, bus.rsp_valid, drv_all, d);
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== (k == 4)) begin
        errors++;
        $display("FAIL mult_latency cycle %0d got vld=%0b want %0b", k, bus.rsp_valid, (k == 4));
      end
      checks++;
      if (drv_all !== 16'h0) begin
        errors++;
        $display("FAIL mult_zero_drive cycle %0d got %h want 0000", k, drv_all);
      end
    end
    checks++;
    if ({bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count} !== {6'd42, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL mult_result got out=%0d err=%0b tag=%0d cnt=%0d want out=42 err=0 tag=0 cnt=0",
               bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count);
    end
    handshake();
    checks++;
    if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL mult_release got vld=%0b rdy=%0b want vld=0 rdy=1", bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_invalid();
    logic [5:0] out;
    logic err;
    logic [3:0] tag;
    bit ok;
    run_cmd(make_cmd(INVALID_6, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag, err_count} !== {1'b1, 6'd0, 1'b1, 4'd1, 8'd1}) begin
      errors++;
      $display("FAIL invalid6 got ok=%0b out=%0d err=%0b tag=%0d cnt=%0d want ok=1 out=0 err=1 tag=1 cnt=1",
               ok, out, err, tag, err_count);
    end
    run_cmd(make_cmd(INVALID_7, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag, err_count} !== {1'b1, 6'd0, 1'b1, 4'd2, 8'd2}) begin
      errors++;
      $display("FAIL invalid7 got ok=%0b out=%0d err=%0b tag=%0d cnt=%0d want ok=1 out=0 err=1 tag=2 cnt=2",
               ok, out, err, tag, err_count);
    end
  endtask

  task automatic test_bypass();
    logic [5:0] out;
    logic err;
    logic [3:0] tag;
    bit ok;
    run_cmd(make_cmd(OR, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag} !== {1'b1, 6'd5, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL bypass got ok=%0b out=%0d err=%0b tag=%0d want ok=1 out=5 err=0 tag=3",
               ok, out, err, tag);
    end
  endtask

  task automatic test_shift_rotate();
    logic [5:0] out;
    logic err;
    logic [3:0] tag;
    bit ok;
    run_cmd(make_cmd(SHIFT, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag} !== {1'b1, 6'b000001, 1'b0, 4'd4}) begin
      errors++;
      $display("FAIL shift_left got ok=%0b out=%b err=%0b tag=%0d want ok=1 out=000001 err=0 tag=4",
               ok, out, err, tag);
    end
    run_cmd(make_cmd(ROTATE, 3'd7, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag} !== {1'b1, 6'd0, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL rotate_right got ok=%0b out=%b err=%0b tag=%0d want ok=1 out=000000 err=0 tag=5",
               ok, out, err, tag);
    end
    run_cmd(make_cmd(ROTATE, 3'd7, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag, err_count} !== {1'b1, 6'd0, 1'b0, 4'd6, 8'd2}) begin
      errors++;
      $display("FAIL rotate_left got ok=%0b out=%b err=%0b tag=%0d cnt=%0d want ok=1 out=000000 err=0 tag=6 cnt=2",
               ok, out, err, tag, err_count);
    end
  endtask

  function automatic logic [15:0] b2b_cmd(int i);
    logic [2:0] a;
    a = 3'(i);
    return make_cmd(ADD, a, 3'd3, a[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic test_back_to_back();
    int  n_acc, n_rsp, a0, last_rsp;
    bit  pending;
    logic [5:0] exp_out;
    do_reset();
    n_acc = 0; n_rsp = 0; a0 = -1; last_rsp = -1; pending = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.cmd_data  = b2b_cmd(0);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 200 && n_rsp < 17; t++) begin
      if (pending) begin
        pending = 1'b0;
        if (n_acc == 17) bus.cmd_valid = 1'b0;
        else bus.cmd_data = b2b_cmd(n_acc);
      end
      if (a0 >= 0) begin
        checks++;
        if (bus.cmd_ready !== (((cyc - a0) % 5) == 0)) begin
          errors++;
          $display("FAIL b2b_ready rel %0d got %0b want %0b", cyc - a0, bus.cmd_ready, (((cyc - a0) % 5) == 0));
        end
      end
      if (bus.rsp_valid) begin
        exp_out = 6'((n_rsp % 8) + 3 + (n_rsp % 2));
        checks++;
        if ({bus.rsp_tag, bus.rsp_out, bus.rsp_err} !== {4'(n_rsp % 16), exp_out, 1'b0}) begin
          errors++;
          $display("FAIL b2b_rsp %0d got tag=%0d out=%0d err=%0b want tag=%0d out=%0d err=0",
                   n_rsp, bus.rsp_tag, bus.rsp_out, bus.rsp_err, n_rsp % 16, exp_out);
        end
        checks++;
        if ((n_rsp == 0 && cyc - a0 != 4) || (n_rsp > 0 && cyc - last_rsp != 5)) begin
          errors++;
          $display("FAIL b2b_spacing %0d got gap=%0d want %0d", n_rsp,
                   (n_rsp == 0) ? cyc - a0 : cyc - last_rsp, (n_rsp == 0) ? 4 : 5);
        end
        last_rsp = cyc;
        n_rsp++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (a0 < 0) a0 = cyc;
        n_acc++;
        pending = 1'b1;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (n_rsp != 17) begin
      errors++;
      $display("FAIL b2b_count got %0d responses want 17", n_rsp);
    end
  endtask

  task automatic test_stall_and_reset();
    logic [5:0] out;
    logic err;
    logic [3:0] tag;
    bit ok;
    int acc;
    // tag counter stands at 1 after the 17 back-to-back commands
    run_cmd(make_cmd(INVALID_7, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, err, tag, err_count} !== {1'b1, 1'b1, 4'd1, 8'd1}) begin
      errors++;
      $display("FAIL stall_pre got ok=%0b err=%0b tag=%0d cnt=%0d want ok=1 err=1 tag=1 cnt=1",
               ok, err, tag, err_count);
    end
    send_cmd(make_cmd(XOR, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), acc, ok);
    if (ok) wait_rsp(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_rsp got timeout want rsp_valid"); end
    bus.cmd_data  = make_cmd(OR, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, bus.cmd_ready, drv_all}
          !== {1'b1, 6'd6, 1'b0, 4'd2, 1'b0, 16'h0}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got vld=%0b out=%0d err=%0b tag=%0d rdy=%0b drv=%h want vld=1 out=6 err=0 tag=2 rdy=0 drv=0000",
                 i, bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, bus.cmd_ready, drv_all);
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    handshake();
    send_cmd(make_cmd(ADD, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), acc, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count, drv_all} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%0b vld=%0b out=%0d err=%0b tag=%0d cnt=%0d drv=%h want all 0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_out, bus.rsp_err, bus.rsp_tag, err_count, drv_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_discard cycle %0d got vld=%0b want 0", i, bus.rsp_valid);
      end
    end
    run_cmd(make_cmd(OR, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), out, err, tag, ok);
    checks++;
    if ({ok, out, err, tag} !== {1'b1, 6'd3, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_tag got ok=%0b out=%0d err=%0b tag=%0d want ok=1 out=3 err=0 tag=0",
               ok, out, err, tag);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_mult();
    test_invalid();
    test_bypass();
    test_shift_rotate();
    test_back_to_back();
    test_stall_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
